sd_playback_sequencer: RTL

Parametrised playback controller that walks a table of NUM_SONGS songs stored on the SD card. It issues block-read requests to the SD read engine whenever the downstream byte FIFO has room for one block, and tracks menu selection, pause, stop, skip and loop. It sits between the button debouncers/edge detectors, the SD state machine, and the FIFO feeding frame assembly.

---
 rtl/sd_playback_pkg.sv | 27 ++
 rtl/sd_playback_sequencer_song_table_mux.sv | 27 ++
 rtl/sd_playback_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sd_playback_pkg.sv
// Shared types and helpers for the SD playback sequencer: state encodings,
// pending-event kinds and index wrap arithmetic.
package sd_playback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_ROOM = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  // Button event latched during FETCH and acted on at sd_done.
  typedef enum logic [1:0] {
    EV_NONE  = 2'd0,
    EV_PAUSE = 2'd1,
    EV_SKIP  = 2'd2,
    EV_STOP  = 2'd3
  } event_t;

  function automatic int unsigned wrap_step(input int unsigned idx, input logic dec,
                                            input int unsigned n);
    if (dec) return (idx == 0) ? n - 1 : idx - 1;
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sd_playback_sequencer_song_table_mux.sv
// Combinational lookup of one song's start address and block count from the
// flattened song table; also used by the display path.
module song_table_mux #(
  parameter int NUM_SONGS = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int IDX_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic [NUM_SONGS*ADDR_W-1:0] song_start,
  input  logic [NUM_SONGS*LEN_W-1:0]  song_blocks,
  input  logic [IDX_W-1:0]            idx,
  output logic [ADDR_W-1:0]           start,
  output logic [LEN_W-1:0]            blocks
);

  always_comb begin
    start  = '0;
    blocks = '0;
    for (int i = 0; i < NUM_SONGS; i++) begin
      if (32'(idx) == i) begin
        start  = song_start[i*ADDR_W +: ADDR_W];
        blocks = song_blocks[i*LEN_W +: LEN_W];
      end
    end
  end

endmodule

// File: rtl/sd_playback_sequencer.sv
// Playback controller: walks the song table, requests one SD block at a time
// when the FIFO has room, and handles select/pause, skip, stop and loop.
module sd_playback_sequencer
  import sd_playback_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 512,
  parameter int IDX_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic                        clk_25mhz,
  input  logic                        rst,
  input  logic [NUM_SONGS*ADDR_W-1:0] song_start,
  input  logic [NUM_SONGS*LEN_W-1:0]  song_blocks,
  input  logic                        btn_select,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_stop,
  input  logic                        loop_en,
  input  logic                        fifo_room,
  input  logic                        fifo_empty,
  input  logic                        sd_done,
  output logic                        sd_read,
  output logic [ADDR_W-1:0]           sd_addr,
  output logic                        stream_en,
  output logic [IDX_W-1:0]            song_num,
  output logic [2:0]                  state_out,
  output logic                        song_done
);

  state_t            state;
  event_t            pend;
  event_t            evt;
  logic [IDX_W-1:0]  pend_idx;
  logic [IDX_W-1:0]  tgt_idx;
  logic [IDX_W-1:0]  prev_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [LEN_W-1:0]  blocks_left;
  logic [LEN_W-1:0]  cur_blocks;
  logic [LEN_W-1:0]  tgt_blocks;
  logic [ADDR_W-1:0] cur_start;
  logic [ADDR_W-1:0] tgt_start;
  logic              resume_drain;
  logic              last_block;
  logic              skip_btn;

  assign state_out  = state;
  assign prev_idx   = IDX_W'(wrap_step(32'(song_num), 1'b1, NUM_SONGS));
  assign next_idx   = IDX_W'(wrap_step(32'(song_num), 1'b0, NUM_SONGS));
  assign last_block = (blocks_left == LEN_W'(1));
  assign skip_btn   = btn_up | btn_down;

  // Fresh buttons override any latched event: stop > skip > pause.
  always_comb begin
    evt     = pend;
    tgt_idx = pend_idx;
    if (btn_up)        tgt_idx = prev_idx;
    else if (btn_down) tgt_idx = next_idx;
    if (btn_stop)        evt = EV_STOP;
    else if (skip_btn)   evt = EV_SKIP;
    else if (btn_select) evt = EV_PAUSE;
  end

  song_table_mux #(
    .NUM_SONGS (NUM_SONGS),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .IDX_W     (IDX_W)
  ) u_cur_mux (
    .song_start  (song_start),
    .song_blocks (song_blocks),
    .idx         (song_num),
    .start       (cur_start),
    .blocks      (cur_blocks)
  );

  song_table_mux #(
    .NUM_SONGS (NUM_SONGS),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .IDX_W     (IDX_W)
  ) u_tgt_mux (
    .song_start  (song_start),
    .song_blocks (song_blocks),
    .idx         (tgt_idx),
    .start       (tgt_start),
    .blocks      (tgt_blocks)
  );

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state        <= ST_IDLE;
      song_num     <= '0;
      sd_addr      <= '0;
      sd_read      <= 1'b0;
      stream_en    <= 1'b0;
      song_done    <= 1'b0;
      blocks_left  <= '0;
      pend         <= EV_NONE;
      pend_idx     <= '0;
      resume_drain <= 1'b0;
    end else begin
      sd_read   <= 1'b0;
      song_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_select) begin
            if (cur_blocks != '0) begin
              sd_addr      <= cur_start;
              blocks_left  <= cur_blocks;
              sd_read      <= 1'b1;
              pend         <= EV_NONE;
              resume_drain <= 1'b0;
              state        <= ST_FETCH;
            end
          end else if (btn_up) begin
            song_num <= prev_idx;
          end else if (btn_down) begin
            song_num <= next_idx;
          end
        end

        ST_FETCH: begin
          if (sd_done) begin
            blocks_left <= blocks_left - LEN_W'(1);
            sd_addr     <= sd_addr + ADDR_W'(ADDR_STEP);
            stream_en   <= 1'b1;
            pend        <= EV_NONE;
            case (evt)
              EV_STOP: begin
                stream_en <= 1'b0;
                state     <= ST_IDLE;
              end
              EV_SKIP: begin
                song_num     <= tgt_idx;
                resume_drain <= 1'b0;
                if (tgt_blocks != '0) begin
                  sd_addr     <= tgt_start;
                  blocks_left <= tgt_blocks;
                  state       <= ST_WAIT_ROOM;
                end else begin
                  blocks_left <= '0;
                  stream_en   <= 1'b0;
                  state       <= ST_IDLE;
                end
              end
              EV_PAUSE: begin
                stream_en    <= 1'b0;
                resume_drain <= last_block;
                state        <= ST_PAUSED;
              end
              default: state <= last_block ? ST_DRAIN : ST_WAIT_ROOM;
            endcase
          end else begin
            pend     <= evt;
            pend_idx <= tgt_idx;
          end
        end

        ST_WAIT_ROOM: begin
          if (btn_stop) begin
            stream_en <= 1'b0;
            state     <= ST_IDLE;
          end else if (skip_btn) begin
            song_num     <= tgt_idx;
            resume_drain <= 1'b0;
            if (tgt_blocks != '0) begin
              sd_addr     <= tgt_start;
              blocks_left <= tgt_blocks;
            end else begin
              blocks_left <= '0;
              stream_en   <= 1'b0;
              state       <= ST_IDLE;
            end
          end else if (btn_select) begin
            stream_en    <= 1'b0;
            resume_drain <= 1'b0;
            state        <= ST_PAUSED;
          end else if (fifo_room) begin
            sd_read <= 1'b1;
            state   <= ST_FETCH;
          end
        end

        ST_PAUSED: begin
          if (btn_stop) begin
            stream_en <= 1'b0;
            state     <= ST_IDLE;
          end else if (skip_btn) begin
            song_num     <= tgt_idx;
            resume_drain <= 1'b0;
            if (tgt_blocks != '0) begin
              sd_addr     <= tgt_start;
              blocks_left <= tgt_blocks;
              state       <= ST_WAIT_ROOM;
            end else begin
              blocks_left <= '0;
              stream_en   <= 1'b0;
              state       <= ST_IDLE;
            end
          end else if (btn_select) begin
            stream_en    <= 1'b1;
            resume_drain <= 1'b0;
            state        <= resume_drain ? ST_DRAIN : ST_WAIT_ROOM;
          end
        end

        ST_DRAIN: begin
          if (btn_stop) begin
            stream_en <= 1'b0;
            state     <= ST_IDLE;
          end else if (fifo_empty) begin
            song_done <= 1'b1;
            if (loop_en) begin
              sd_addr     <= cur_start;
              blocks_left <= cur_blocks;
              sd_read     <= 1'b1;
              state       <= ST_FETCH;
            end else begin
              song_num  <= next_idx;
              stream_en <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
